// File: rtl/ped_request.sv
// rtl/ped_request.sv - pedestrian push-button front end with request latch and WAIT lamp
//
// Purpose:
//   Synchronises and debounces a raw active-low push button. Each debounced
//   press produces a one-cycle o_press pulse. The first press latches a
//   crossing request that is held until the controller acknowledges it.
//   While the request is pending, the WAIT lamp blinks.
//
// Ports:
//   i_pin3_clk_16mhz  in   system clock
//   i_rst             in   synchronous reset, active-high
//   i_pin9_button     in   raw button, asynchronous, active-low (pull-up)
//   i_ack             in   one-cycle grant pulse from the controller
//   o_press           out  one-cycle pulse per debounced press
//   o_request         out  latched crossing request
//   o_pin10_wait      out  WAIT lamp, blinks while the request is pending

module ped_request #(
  parameter int TIMER_SCALE    = 16000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int BLINK_TICKS    = 250
) (
  input  logic i_pin3_clk_16mhz,
  input  logic i_rst,
  input  logic i_pin9_button,
  input  logic i_ack,
  output logic o_press,
  output logic o_request,
  output logic o_pin10_wait
);

  localparam int PS_W = (TIMER_SCALE    > 1) ? $clog2(TIMER_SCALE)    : 1;
  localparam int DB_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam int BL_W = (BLINK_TICKS    > 1) ? $clog2(BLINK_TICKS)    : 1;

  localparam logic [PS_W-1:0] PS_MAX = PS_W'(TIMER_SCALE - 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVED  = 2'd2
  } state_t;

  logic [PS_W-1:0] prescaler;
  logic            tick;
  logic            sync1;
  logic            sync2;
  logic            stable;
  logic            stable_q;
  logic [DB_W-1:0] deb_cnt;
  logic [BL_W-1:0] blink_cnt;
  state_t          state;

  // Time base shared by debounce and blink; with TIMER_SCALE=1 it ticks every cycle.
  assign tick = (prescaler == PS_MAX);

  always_ff @(posedge i_pin3_clk_16mhz) begin
    if (i_rst) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Two-flop synchroniser; resets to the released (high) level.
  always_ff @(posedge i_pin3_clk_16mhz) begin
    if (i_rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= i_pin9_button;
      sync2 <= sync1;
    end
  end

  // Debounce: the synchronised level must differ from the accepted level for
  // DEBOUNCE_TICKS consecutive ticks before it is accepted. Any return to the
  // accepted level restarts the count.
  // o_press compares the accepted level with its one-cycle-old copy, so the
  // pulse appears the cycle after the accepted level falls.
  always_ff @(posedge i_pin3_clk_16mhz) begin
    if (i_rst) begin
      stable   <= 1'b1;
      stable_q <= 1'b1;
      deb_cnt  <= '0;
      o_press  <= 1'b0;
    end else begin
      stable_q <= stable;
      o_press  <= stable_q & ~stable;
      if (sync2 == stable) begin
        deb_cnt <= '0;
      end else if (tick) begin
        if (deb_cnt == DB_MAX) begin
          stable  <= sync2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end
    end
  end

  // Request FSM with registered outputs. The blink counter only runs in
  // PENDING, so every new request starts with a full lit half-period.
  always_ff @(posedge i_pin3_clk_16mhz) begin
    if (i_rst) begin
      state        <= IDLE;
      o_request    <= 1'b0;
      o_pin10_wait <= 1'b0;
      blink_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          blink_cnt <= '0;
          if (o_press) begin
            state        <= PENDING;
            o_request    <= 1'b1;
            o_pin10_wait <= 1'b1;
          end else begin
            o_request    <= 1'b0;
            o_pin10_wait <= 1'b0;
          end
        end
        PENDING: begin
          // Ack takes priority; further presses while pending are ignored.
          if (i_ack) begin
            state        <= SERVED;
            o_request    <= 1'b0;
            o_pin10_wait <= 1'b0;
            blink_cnt    <= '0;
          end else begin
            o_request <= 1'b1;
            if (tick) begin
              if (blink_cnt == BL_MAX) begin
                blink_cnt    <= '0;
                o_pin10_wait <= ~o_pin10_wait;
              end else begin
                blink_cnt <= blink_cnt + 1'b1;
              end
            end
          end
        end
        SERVED: begin
          // Wait for a debounced release so a button held across the ack
          // cannot raise a second request.
          o_request    <= 1'b0;
          o_pin10_wait <= 1'b0;
          blink_cnt    <= '0;
          if (stable) begin
            state <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          o_request    <= 1'b0;
          o_pin10_wait <= 1'b0;
          blink_cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ped_request.sv
// tb/tb_ped_request.sv - self-checking bench for ped_request

module tb_ped_request;

  logic clk = 1'b0;
  logic rst;
  logic button;
  logic ack;
  logic press;
  logic request;
  logic wait_lamp;

  int checks = 0;
  int passed = 0;

  // Expected {o_press, o_request, o_pin10_wait} per clock edge.
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  ped_request #(
    .TIMER_SCALE(1),
    .DEBOUNCE_TICKS(4),
    .BLINK_TICKS(3)
  ) dut (
    .i_pin3_clk_16mhz(clk),
    .i_rst(rst),
    .i_pin9_button(button),
    .i_ack(ack),
    .o_press(press),
    .o_request(request),
    .o_pin10_wait(wait_lamp)
  );

  // Apply inputs for the next edge, queue the expected outputs after it,
  // then advance past the edge so outputs can be sampled.
  task automatic drive(input logic r, input logic b, input logic a, input logic [2:0] e);
    rst    = r;
    button = b;
    ack    = a;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] e;
    logic [2:0] got;
    for (int k = 1; k <= 6; k++) begin
      if (k <= 3) drive(1'b1, 1'b0, 1'b0, 3'b000);
      else        drive(1'b0, 1'b1, 1'b0, 3'b000);
      e   = exp_q.pop_front();
      got = {press, request, wait_lamp};
      checks++;
      if (got !== e) $display("FAIL reset k=%0d got p/r/w=%b exp=%b", k, got, e);
      else passed++;
    end
  endtask

  task automatic test_short_pulse();
    logic [2:0] e;
    logic [2:0] got;
    for (int k = 1; k <= 12; k++) begin
      drive(1'b0, (k > 3), 1'b0, 3'b000);
      e   = exp_q.pop_front();
      got = {press, request, wait_lamp};
      checks++;
      if (got !== e) $display("FAIL short_pulse k=%0d got p/r/w=%b exp=%b", k, got, e);
      else passed++;
    end
  endtask

  // Button low from edge 1; press at edge 7, request from edge 8, lamp
  // lit for 3 edges then toggling every 3 edges.
  task automatic test_long_press();
    logic [2:0] e;
    logic [2:0] got;
    logic p, r, w;
    for (int k = 1; k <= 20; k++) begin
      p = (k == 7);
      r = (k >= 8);
      w = r && ((((k - 8) / 3) % 2) == 0);
      drive(1'b0, 1'b0, 1'b0, {p, r, w});
      e   = exp_q.pop_front();
      got = {press, request, wait_lamp};
      checks++;
      if (got !== e) $display("FAIL long_press k=%0d got p/r/w=%b exp=%b", k, got, e);
      else passed++;
    end
  endtask

  // Continues edge numbering from test_long_press. Release at 21, press
  // again at 31 (pulse at 37), ack at 38 coinciding with the FSM seeing
  // that second press: ack must win and request must drop.
  task automatic test_press_then_ack();
    logic [2:0] e;
    logic [2:0] got;
    logic p, r, w;
    for (int k = 21; k <= 45; k++) begin
      p = (k == 37);
      r = (k <= 37);
      w = r && ((((k - 8) / 3) % 2) == 0);
      drive(1'b0, (k <= 30), (k == 38), {p, r, w});
      e   = exp_q.pop_front();
      got = {press, request, wait_lamp};
      checks++;
      if (got !== e) $display("FAIL press_then_ack k=%0d got p/r/w=%b exp=%b", k, got, e);
      else passed++;
    end
  endtask

  // Button held since before the ack; released at 46 (accepted at 51, IDLE
  // at 52), pressed at 53 -> pulse at 59, new request from 60.
  task automatic test_held_through_ack();
    logic [2:0] e;
    logic [2:0] got;
    logic p, r, w;
    for (int k = 46; k <= 66; k++) begin
      p = (k == 59);
      r = (k >= 60);
      w = r && ((((k - 60) / 3) % 2) == 0);
      drive(1'b0, (k <= 52), 1'b0, {p, r, w});
      e   = exp_q.pop_front();
      got = {press, request, wait_lamp};
      checks++;
      if (got !== e) $display("FAIL held_through_ack k=%0d got p/r/w=%b exp=%b", k, got, e);
      else passed++;
    end
  endtask

  task automatic test_reset_while_pending();
    logic [2:0] e;
    logic [2:0] got;
    checks++;
    if (request !== 1'b1) $display("FAIL pending_before_reset got=%b exp=1", request);
    else passed++;
    drive(1'b1, 1'b1, 1'b1, 3'b000);
    e   = exp_q.pop_front();
    got = {press, request, wait_lamp};
    checks++;
    if (got !== e) $display("FAIL reset_while_pending got p/r/w=%b exp=%b", got, e);
    else passed++;
  endtask

  task automatic test_ack_in_idle();
    logic [2:0] e;
    logic [2:0] got;
    for (int k = 1; k <= 10; k++) begin
      drive(1'b0, 1'b1, (k == 3 || k == 4), 3'b000);
      e   = exp_q.pop_front();
      got = {press, request, wait_lamp};
      checks++;
      if (got !== e) $display("FAIL ack_in_idle k=%0d got p/r/w=%b exp=%b", k, got, e);
      else passed++;
    end
  endtask

  initial begin
    rst    = 1'b1;
    button = 1'b1;
    ack    = 1'b0;
    test_reset();
    test_short_pulse();
    test_long_press();
    test_press_then_ack();
    test_held_through_ack();
    test_reset_while_pending();
    test_ack_in_idle();
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
